// File: rtl/irq83_pkg.sv
// rtl/irq83_pkg.sv - shared types and constants for the irq_ctrl83 interrupt controller
package irq83_pkg;

    localparam int NUM_IRQ = 8;
    localparam int VEC_W   = 3;

    localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Rotate right so that bit n lands at position 0 and bit n-1 at position 7.
    function automatic logic [NUM_IRQ-1:0] rotr8(input logic [NUM_IRQ-1:0] v,
                                                 input logic [VEC_W-1:0]   n);
        logic [NUM_IRQ-1:0] r;
        logic [VEC_W-1:0]   src;
        r = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            src  = VEC_W'(i) + n;
            r[i] = v[src];
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc83.sv
// rtl/prio_enc83.sv - combinational 8-to-3 priority encoder, bit 7 highest
module prio_enc83
    import irq83_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Ascending scan: the highest set bit is the last one written.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl83.sv
// rtl/irq_ctrl83.sv - 8-line edge-latched interrupt controller; IRQ83_ROTATE_EN selects rotating priority
module irq_ctrl83
    import irq83_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IRQ-1:0]   irq_i,
    input  logic                 mask_we,
    input  logic [NUM_IRQ-1:0]   mask_wdata,
    input  logic                 irq_ack,
    input  logic                 irq_eoi,
    output logic                 irq_req,
    output logic [VEC_W-1:0]     irq_vec,
    output logic                 in_service,
    output logic [NUM_IRQ-1:0]   pending_o,
    output logic [NUM_IRQ-1:0]   mask_o
);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] enc_in;
    logic [VEC_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [VEC_W-1:0]   win_vec;
    logic [VEC_W-1:0]   vec;
    logic               ack_take;
    logic               eoi_take;

    assign edge_det = irq_i & ~irq_q;
    assign eligible = pending & ~mask;
    assign ack_take = (state == REQ) && irq_ack;
    assign eoi_take = (state == SERVICE) && irq_eoi;
    assign ack_clr  = ack_take ? (NUM_IRQ'(1) << vec) : '0;

`ifdef IRQ83_ROTATE_EN
    logic [VEC_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (eoi_take) begin
            ptr <= vec;
        end
    end

    // Encode in rotated space, then shift the winner back to a real line index.
    assign enc_in  = rotr8(eligible, ptr);
    assign win_vec = enc_idx + ptr;
`else
    assign enc_in  = eligible;
    assign win_vec = enc_idx;
`endif

    prio_enc83 u_enc (
        .req   (enc_in),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Edge detector, pending latch and mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= MASK_RST;
        end else begin
            irq_q   <= irq_i;
            // Set after clear: a new edge on the line being acked is kept.
            pending <= (pending & ~ack_clr) | edge_det;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector is captured only on the IDLE->REQ transition and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            irq_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            if ((state == IDLE) && enc_valid) begin
                vec <= win_vec;
            end
            irq_req    <= (state_nxt == REQ);
            in_service <= (state_nxt == SERVICE);
        end
    end

    assign irq_vec   = vec;
    assign pending_o = pending;
    assign mask_o    = mask;

endmodule

// File: tb/tb_irq_ctrl83.sv
// tb/tb_irq_ctrl83.sv - scoreboard testbench for irq_ctrl83
module tb_irq_ctrl83;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_i;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       irq_ack;
    logic       irq_eoi;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic       in_service;
    logic [7:0] pending_o;
    logic [7:0] mask_o;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] exp_q[$];

    irq_ctrl83 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_i      (irq_i),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .in_service (in_service),
        .pending_o  (pending_o),
        .mask_o     (mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq_i = bits;
        tick();
        irq_i = 8'h00;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int         n;
        logic [2:0] e;
        n = 0;
        while (!irq_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(irq_req), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        check({tag, "_vec"}, 32'(irq_vec), 32'(e));
    endtask

    task automatic serve(input string tag);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check({tag, "_ack_req"}, 32'(irq_req), 32'd0);
        check({tag, "_ack_svc"}, 32'(in_service), 32'd1);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check({tag, "_eoi_svc"}, 32'(in_service), 32'd0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        irq_i      = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        irq_ack    = 1'b0;
        irq_eoi    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_svc", 32'(in_service), 32'd0);
        check("rst_pend", 32'(pending_o), 32'h00);
        check("rst_mask", 32'(mask_o), 32'hFF);

        // Two simultaneous edges: 5 first, then 3 after one idle cycle.
        write_mask(8'h00);
        check("mask0", 32'(mask_o), 32'h00);
        pulse(8'h28);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd3);
        check("t1_pend", 32'(pending_o), 32'h28);
        check("t1_req_early", 32'(irq_req), 32'd0);
        tick();
        check("t1_latency", 32'(irq_req), 32'd1);
        wait_grant("t1_a");
        serve("t1_a");
        check("t1_pend_after", 32'(pending_o), 32'h08);
        check("t1_gap", 32'(irq_req), 32'd0);
        tick();
        check("t1_next_req", 32'(irq_req), 32'd1);
        wait_grant("t1_b");
        serve("t1_b");

        // Masked line latches and fires once unmasked.
        write_mask(8'h04);
        pulse(8'h04);
        tick();
        check("t2_pend", 32'(pending_o), 32'h04);
        check("t2_masked_req", 32'(irq_req), 32'd0);
        write_mask(8'h00);
        exp_q.push_back(3'd2);
        check("t2_unmask_lag", 32'(irq_req), 32'd0);
        wait_grant("t2");
        serve("t2");

        // Vector frozen in REQ despite a higher-priority edge.
        pulse(8'h02);
        exp_q.push_back(3'd1);
        wait_grant("t3_a");
        pulse(8'h40);
        tick();
        check("t3_frozen", 32'(irq_vec), 32'd1);
        check("t3_still_req", 32'(irq_req), 32'd1);
        serve("t3_a");
        exp_q.push_back(3'd6);
        wait_grant("t3_b");
        serve("t3_b");

        // New edge on granted line coincides with ack.
        pulse(8'h01);
        exp_q.push_back(3'd0);
        wait_grant("t4_a");
        irq_ack = 1'b1;
        irq_i   = 8'h01;
        tick();
        irq_ack = 1'b0;
        irq_i   = 8'h00;
        check("t4_pend_kept", 32'(pending_o), 32'h01);
        check("t4_svc", 32'(in_service), 32'd1);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        exp_q.push_back(3'd0);
        wait_grant("t4_b");
        serve("t4_b");

        // Stray handshakes are ignored.
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5_ack_idle_req", 32'(irq_req), 32'd0);
        check("t5_ack_idle_svc", 32'(in_service), 32'd0);
        pulse(8'h10);
        exp_q.push_back(3'd4);
        wait_grant("t5");
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check("t5_eoi_req", 32'(irq_req), 32'd1);
        check("t5_eoi_svc", 32'(in_service), 32'd0);
        check("t5_eoi_vec", 32'(irq_vec), 32'd4);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5_svc", 32'(in_service), 32'd1);

        // Asynchronous reset during SERVICE with a pending line.
        pulse(8'h80);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(irq_req), 32'd0);
        check("t6_vec", 32'(irq_vec), 32'd0);
        check("t6_svc", 32'(in_service), 32'd0);
        check("t6_pend", 32'(pending_o), 32'h00);
        check("t6_mask", 32'(mask_o), 32'hFF);
        do_reset();

        // Priority after serving line 7.
        write_mask(8'h00);
        pulse(8'h80);
        exp_q.push_back(3'd7);
        wait_grant("t7_a");
        serve("t7_a");
        pulse(8'h90);
`ifdef IRQ83_ROTATE_EN
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd7);
`else
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
`endif
        wait_grant("t7_b");
        serve("t7_b");
        wait_grant("t7_c");
        serve("t7_c");
        tick();
        check("end_pend", 32'(pending_o), 32'h00);
        check("end_q", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl83.md
# irq_ctrl83

Eight-input interrupt controller that sequences the 8-to-3 priority encoder datapath. It latches rising edges on eight request lines into a pending register and gates them with a software-loaded mask. It selects one winner through the priority encoder and presents it as a 3-bit vector. A request/acknowledge/end-of-interrupt handshake serialises service to a single consumer (CPU or bus master).

## Interface
- No parameters; width fixed at 8 requesters / 3-bit vector.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- irq_i  in  8  interrupt lines, level input, rising-edge sensitive; bit 7 = highest fixed priority
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  8  new mask; 1 = line masked
- irq_ack  in  1  consumer accepts presented vector (1-cycle pulse)
- irq_eoi  in  1  consumer finished service (1-cycle pulse)
- irq_req  out  1  vector valid, awaiting ack
- irq_vec  out  3  index of granted line
- in_service  out  1  granted interrupt being serviced
- pending_o  out  8  pending register, raw
- mask_o  out  8  mask register

## Operation
- Edge detect: irq_q <= irq_i each cycle; edge = irq_i & ~irq_q. irq_q resets to 0, so a line high at reset release registers an edge on the first clock.
- pending[n] set on edge[n]; cleared only by ack of vector n. A set and a clear of the same bit in the same cycle: set wins (a new edge is never lost).
- eligible = pending & ~mask. Masked lines still latch pending and fire once unmasked.
- Mask write takes effect the cycle after mask_we.
- FSM states IDLE, REQ, SERVICE:
  - IDLE -> REQ when eligible != 0; irq_vec <= encoder(eligible), frozen while in REQ/SERVICE.
  - REQ -> SERVICE on irq_ack; pending[irq_vec] cleared on the same edge.
  - SERVICE -> IDLE on irq_eoi.
- Vector is frozen in REQ. Later higher-priority edges or mask changes do not retract or alter it; they are arbitrated after EOI.
- irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
- No nesting; one interrupt in service at a time.

## Timing
- Reset values: irq_req 0, irq_vec 3'd0, in_service 0, pending_o 8'h00, mask_o 8'hFF (all masked), FSM IDLE, rotation pointer 3'd0.
- irq_i first sampled high at edge k: pending_o set after edge k, irq_req high after edge k+1. Latency is 2 cycles, provided the FSM is idle and the line is unmasked.
- irq_ack sampled at edge m: irq_req low and in_service high after m.
- irq_eoi at edge e: in_service low after e. The next eligible request is asserted after e+1, so there is a minimum 1 idle cycle between services.
- All outputs are registered; no combinational input-to-output paths.
- Reset mid-operation: immediate return to reset values, and all pending edges are discarded.

## Configuration
- IRQ83_ROTATE_EN defined: rotating priority.
  - On EOI of vector v, the pointer becomes v.
  - Priority then descends from (v-1) mod 8 down to v, so v is lowest.
  - Pointer reset 0 gives initial order 7..0, identical to fixed.
- Undefined: fixed priority, 7 highest, 0 lowest. No pointer register is synthesised.

## Structure
- Package irq83_pkg:
  - state typedef (IDLE, REQ, SERVICE)
  - NUM_IRQ = 8, VEC_W = 3
  - MASK_RST = 8'hFF
- Sub-module prio_enc83: combinational 8-to-3 priority encoder with valid output, bit 7 highest. Rotation is done outside it by rotating the eligible vector by the pointer and adding the offset back to the result.

## Test plan
- Reset then mask_wdata 8'h00. Pulse irq_i[3] and irq_i[5] in the same cycle -> irq_vec 5 after 2 cycles. Ack, EOI -> irq_vec 3 one cycle later.
- mask 8'h04, pulse irq_i[2] -> pending_o 8'h04, irq_req stays 0. Write mask 8'h00 -> irq_req 1, irq_vec 2.
- In REQ with vec 1, pulse irq_i[6] -> irq_vec stays 1. Ack/EOI -> vec 6 served next.
- Ack on the same cycle as a new edge on the granted line -> pending bit remains 1, and the line is re-requested after EOI.
- Stray irq_ack in IDLE and irq_eoi in REQ -> no state change.
- Assert rst_n low during SERVICE -> all outputs at reset values within the same cycle. With IRQ83_ROTATE_EN, serve vec 7, then raise lines 7 and 4 together -> vec 4 wins.
